spi_target: RTL and testbench

SPI target (slave) byte engine: the responder-side counterpart of the SPI controller core. It samples an external controller's `sck_i`, `cs_ni` and `mosi_i` into the `clk_i` domain and supports all four CPOL/CPHA modes and MSB/LSB-first ordering. It drives `miso_o` and exchanges bytes with local logic over valid/ready handshakes. It sits between the SPI pins and a register front end or a DMA/bridge.

---
 rtl/spi_target.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_target.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// spi_target: SPI target (slave) byte engine.
// Samples an external controller's sck/cs_n/mosi into the clk_i domain and supports all
// four CPOL/CPHA modes with MSB- or LSB-first ordering. Bytes move to and from local logic
// over valid/ready handshakes.
// Optional feature: define SPI_TARGET_OVERRUN_EN to drop bytes that arrive while the previous
// RX byte is still unclaimed and to raise a sticky overrun_o. Without it, new bytes overwrite.
module spi_target #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  DEFAULT_FILL = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       pol_i,
  input  logic       pha_i,
  input  logic       lsb_first_i,
  input  logic       sck_i,
  input  logic       cs_ni,
  input  logic       mosi_i,
  output logic       miso_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o,
  output logic       overrun_o
);

  typedef enum logic {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;

  state_e     r_state;
  state_e     w_state_d;
  logic [2:0] r_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_byte;
  logic [7:0] r_tx_hold;
  logic       r_tx_full;
  logic       r_miso;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  logic       w_sck;
  logic       w_cs_n;
  logic       w_mosi;
  logic       w_sck_edge;
  logic       w_lead;
  logic       w_trail;
  logic       w_go;
  logic       w_enter;
  logic       w_exit;
  logic       w_run;
  logic       w_do_sample;
  logic       w_do_shift;
  logic       w_byte_done;
  logic       w_load;
  logic [7:0] w_load_byte;
  logic [2:0] w_idx;
  logic [2:0] w_first_idx;
  logic [7:0] w_rx_next;

  // Pin synchronizers; cs_n presets high so the block starts deselected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_ni};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_sck_prev  <= w_sck;
    end
  end

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign w_sck_edge = w_sck ^ r_sck_prev;
  assign w_lead     = w_sck_edge & (r_sck_prev == pol_i);
  assign w_trail    = w_sck_edge & (w_sck == pol_i);

  assign w_go  = ~w_cs_n & en_i;
  assign w_run = (r_state == StActive) & w_go;

  assign w_do_sample = w_run & (pha_i ? w_trail : w_lead);
  assign w_do_shift  = w_run & (pha_i ? w_lead : w_trail);
  assign w_byte_done = w_do_sample & (r_cnt == 3'd7);
  assign w_load      = w_enter | w_byte_done;
  assign w_load_byte = r_tx_full ? r_tx_hold : DEFAULT_FILL;

  // cnt is a transfer-order index; map it to a physical bit position.
  assign w_idx       = lsb_first_i ? r_cnt : (3'd7 - r_cnt);
  assign w_first_idx = lsb_first_i ? 3'd0 : 3'd7;

  // Next-state decode for the idle/active FSM.
  always_comb begin
    w_state_d = r_state;
    w_enter   = 1'b0;
    w_exit    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_go) begin
          w_state_d = StActive;
          w_enter   = 1'b1;
        end
      end
      StActive: begin
        if (!w_go) begin
          w_state_d = StIdle;
          w_exit    = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  // RX shift contents including the bit being sampled this cycle.
  always_comb begin
    w_rx_next        = r_rx_shift;
    w_rx_next[w_idx] = w_mosi;
  end

  // Bit counter and RX shift register; any exit discards a partial byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_enter || w_exit) begin
      r_cnt      <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_do_sample) begin
      r_cnt      <= r_cnt + 3'd1;
      r_rx_shift <= w_rx_next;
    end
  end

  // TX holding register and active TX byte; a load consumes the held byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_byte <= 8'h00;
      r_tx_hold <= 8'h00;
      r_tx_full <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_byte <= w_load_byte;
        if (r_tx_full) r_tx_full <= 1'b0;
      end
      // No bypass: a capture in a load cycle is held for the following byte.
      if (tx_valid_i && tx_ready_o) begin
        r_tx_hold <= tx_data_i;
        r_tx_full <= 1'b1;
      end
    end
  end

  // MISO driver: first bit presented on entry in CPHA=0, then one bit per shift edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_miso <= 1'b0;
    end else if (w_exit) begin
      r_miso <= 1'b0;
    end else if (w_enter && !pha_i) begin
      r_miso <= w_load_byte[w_first_idx];
    end else if (w_do_shift) begin
      r_miso <= r_tx_byte[w_idx];
    end
  end

  // RX output handshake; completion wins over a same-cycle accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else if (w_byte_done) begin
`ifdef SPI_TARGET_OVERRUN_EN
      if (!r_rx_valid || rx_ready_i) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
      end
`else
      r_rx_data  <= w_rx_next;
      r_rx_valid <= 1'b1;
`endif
    end else if (r_rx_valid && rx_ready_i) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_TARGET_OVERRUN_EN
  logic r_overrun;

  // Sticky overrun: a byte finished while the previous one was still unclaimed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun <= 1'b0;
    end else if (!en_i) begin
      r_overrun <= 1'b0;
    end else if (w_byte_done && r_rx_valid && !rx_ready_i) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun_o = r_overrun;
`else
  assign overrun_o = 1'b0;
`endif

  assign miso_o     = r_miso;
  assign tx_ready_o = ~r_tx_full;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign busy_o     = (r_state == StActive);

endmodule

// File: tb/tb_spi_target.sv
// Testbench for spi_target: an SPI controller model drives the pins; expected MISO bytes
// come from a queue model of TX byte loads and expected RX bytes are the bytes sent.
module tb_spi_target;

  localparam int unsigned SS = 2;
  localparam int unsigned H  = 8;  // clk_i periods per SCK phase

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic       pol_i;
  logic       pha_i;
  logic       lsb_first_i;
  logic       sck_i;
  logic       cs_ni;
  logic       mosi_i;
  logic       miso_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       busy_o;
  logic       overrun_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] rx_q[$];
  int         rx_valid_cnt  = 0;
  logic       rx_valid_prev = 1'b0;
  logic [7:0] tx_model_q[$];
  logic [7:0] mosi_bytes[4];
  logic [7:0] miso_bytes[4];
  logic       ready_seen;

  spi_target #(
    .SYNC_STAGES (SS),
    .DEFAULT_FILL(8'hFF)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .pol_i      (pol_i),
    .pha_i      (pha_i),
    .lsb_first_i(lsb_first_i),
    .sck_i      (sck_i),
    .cs_ni      (cs_ni),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // RX monitor: counts valid assertions and records accepted bytes.
  always @(negedge clk_i) begin
    if (rx_valid_o && !rx_valid_prev) rx_valid_cnt++;
    rx_valid_prev = rx_valid_o;
    if (rx_valid_o && rx_ready_i) rx_q.push_back(rx_data_o);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Every byte load takes the queued TX byte if any, else the fill pattern.
  function automatic logic [7:0] model_load();
    if (tx_model_q.size() > 0) return tx_model_q.pop_front();
    return 8'hFF;
  endfunction

  function automatic logic get_bit(input logic [7:0] b, input logic [2:0] i, input logic lsb);
    return lsb ? b[i] : b[3'd7 - i];
  endfunction

  task automatic send_tx(input logic [7:0] d);
    int w;
    w = 0;
    while (tx_ready_o !== 1'b1 && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    n_total++;
    if (tx_ready_o !== 1'b1) $display("FAIL tx_ready_wait: tx_ready_o=%b required 1", tx_ready_o);
    else n_pass++;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    tx_model_q.push_back(d);
  endtask

  // Controller model: one CS window of nbits; optionally queues t1 right after CS fall.
  task automatic spi_xfer(input logic pol, input logic pha, input logic lsb, input int nbits,
                          input logic q1, input logic [7:0] t1);
    logic [2:0] bi;
    logic [2:0] pos;
    pol_i       = pol;
    pha_i       = pha;
    lsb_first_i = lsb;
    sck_i       = pol;
    cs_ni       = 1'b1;
    mosi_i      = 1'b0;
    for (int k = 0; k < 4; k++) miso_bytes[k] = 8'h00;
    repeat (6) @(negedge clk_i);
    cs_ni = 1'b0;
    if (!pha) mosi_i = get_bit(mosi_bytes[0], 3'd0, lsb);
    repeat (SS + 3) @(negedge clk_i);
    ready_seen = tx_ready_o;
    if (q1) begin
      tx_data_i  = t1;
      tx_valid_i = 1'b1;
    end
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    repeat (H - SS - 4) @(negedge clk_i);
    for (int i = 0; i < nbits; i++) begin
      bi  = i[2:0];
      pos = lsb ? bi : (3'd7 - bi);
      sck_i = ~pol;
      if (!pha) miso_bytes[i / 8][pos] = miso_o;
      else mosi_i = get_bit(mosi_bytes[i / 8], bi, lsb);
      repeat (H) @(negedge clk_i);
      sck_i = pol;
      if (pha) miso_bytes[i / 8][pos] = miso_o;
      else if (i + 1 < nbits) mosi_i = get_bit(mosi_bytes[(i + 1) / 8], bi + 3'd1, lsb);
      repeat (H) @(negedge clk_i);
    end
    cs_ni = 1'b1;
    repeat (H) @(negedge clk_i);
  endtask

  task automatic test_reset();
    n_total++;
    if ({miso_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o, overrun_o} !== 13'b0_1_0_00000000_0_0)
      $display("FAIL reset_in: got %b required 0_1_0_00000000_0_0",
               {miso_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o, overrun_o});
    else n_pass++;
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    n_total++;
    if ({busy_o, tx_ready_o, rx_valid_o} !== 3'b010)
      $display("FAIL reset_out: busy/ready/valid=%b required 010", {busy_o, tx_ready_o, rx_valid_o});
    else n_pass++;
  endtask

  task automatic test_mode0_msb();
    logic [7:0] e0;
    int vc;
    rx_q.delete();
    send_tx(8'hA5);
    mosi_bytes[0] = 8'h3C;
    e0 = model_load();
    void'(model_load());
    vc = rx_valid_cnt;
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 1'b0, 8'h00);
    n_total++;
    if (miso_bytes[0] !== e0) $display("FAIL m0_miso: got %h required %h", miso_bytes[0], e0);
    else n_pass++;
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C)
      $display("FAIL m0_rx: got %0d bytes first %h required 1 byte 3c", rx_q.size(), rx_q[0]);
    else n_pass++;
    n_total++;
    if (rx_valid_cnt - vc != 1) $display("FAIL m0_valid_cnt: got %0d required 1", rx_valid_cnt - vc);
    else n_pass++;
    n_total++;
    if (ready_seen !== 1'b1) $display("FAIL m0_tx_ready: got %b required 1", ready_seen);
    else n_pass++;
  endtask

  task automatic test_mode3_lsb();
    logic [7:0] e0;
    rx_q.delete();
    send_tx(8'h01);
    mosi_bytes[0] = 8'h80;
    e0 = model_load();
    void'(model_load());
    spi_xfer(1'b1, 1'b1, 1'b1, 8, 1'b0, 8'h00);
    n_total++;
    if (miso_bytes[0][0] !== 1'b1) $display("FAIL m3_first_bit: got %b required 1", miso_bytes[0][0]);
    else n_pass++;
    n_total++;
    if (miso_bytes[0] !== e0) $display("FAIL m3_miso: got %h required %h", miso_bytes[0], e0);
    else n_pass++;
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h80)
      $display("FAIL m3_rx: got %0d bytes first %h required 1 byte 80", rx_q.size(), rx_q[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e[2];
    rx_q.delete();
    mosi_bytes[0] = 8'($urandom);
    mosi_bytes[1] = 8'($urandom);
    e[0] = model_load();
    e[1] = model_load();
    void'(model_load());
    spi_xfer(1'b1, 1'b0, 1'b0, 16, 1'b0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (miso_bytes[k] !== e[k]) $display("FAIL b2b_miso%0d: got %h required %h", k, miso_bytes[k], e[k]);
      else n_pass++;
    end
    n_total++;
    if (rx_q.size() != 2 || rx_q[0] !== mosi_bytes[0] || rx_q[1] !== mosi_bytes[1])
      $display("FAIL b2b_rx: got %0d bytes %h %h required %h %h", rx_q.size(), rx_q[0], rx_q[1],
               mosi_bytes[0], mosi_bytes[1]);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] e0;
    int vc;
    rx_q.delete();
    send_tx(8'hC3);
    mosi_bytes[0] = 8'($urandom);
    e0 = model_load();
    vc = rx_valid_cnt;
    spi_xfer(1'b0, 1'b1, 1'b0, 5, 1'b0, 8'h00);
    n_total++;
    if (miso_bytes[0][7:3] !== e0[7:3])
      $display("FAIL abort_miso: got %b required %b", miso_bytes[0][7:3], e0[7:3]);
    else n_pass++;
    n_total++;
    if (rx_valid_cnt != vc || rx_q.size() != 0)
      $display("FAIL abort_no_rx: got %0d valids required 0", rx_valid_cnt - vc);
    else n_pass++;
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy_o);
    else n_pass++;
    // Next transfer must start at bit 0; the aborted byte is not re-sent.
    mosi_bytes[0] = 8'($urandom);
    e0 = model_load();
    void'(model_load());
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 1'b0, 8'h00);
    n_total++;
    if (miso_bytes[0] !== e0) $display("FAIL abort_next_miso: got %h required %h", miso_bytes[0], e0);
    else n_pass++;
    n_total++;
    if (rx_q.size() != 1 || rx_q[0] !== mosi_bytes[0])
      $display("FAIL abort_next_rx: got %0d bytes %h required %h", rx_q.size(), rx_q[0], mosi_bytes[0]);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [7:0] exp_data;
    logic       exp_ov;
`ifdef SPI_TARGET_OVERRUN_EN
    exp_data = 8'h11;
    exp_ov   = 1'b1;
`else
    exp_data = 8'h22;
    exp_ov   = 1'b0;
`endif
    rx_ready_i    = 1'b0;
    mosi_bytes[0] = 8'h11;
    mosi_bytes[1] = 8'h22;
    void'(model_load());
    void'(model_load());
    void'(model_load());
    spi_xfer(1'b0, 1'b0, 1'b0, 16, 1'b0, 8'h00);
    n_total++;
    if ({rx_valid_o, rx_data_o, overrun_o} !== {1'b1, exp_data, exp_ov})
      $display("FAIL overrun: valid/data/ov got %b/%h/%b required 1/%h/%b", rx_valid_o, rx_data_o,
               overrun_o, exp_data, exp_ov);
    else n_pass++;
    rx_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_total++;
    if (rx_valid_o !== 1'b0) $display("FAIL overrun_accept: rx_valid_o=%b required 0", rx_valid_o);
    else n_pass++;
    en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_total++;
    if (overrun_o !== 1'b0) $display("FAIL overrun_clear: got %b required 0", overrun_o);
    else n_pass++;
    en_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rx_q.delete();
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] e0;
    pol_i = 1'b0; pha_i = 1'b0; lsb_first_i = 1'b0; sck_i = 1'b0; cs_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    cs_ni  = 1'b0;
    mosi_i = 1'b1;
    repeat (SS + 3) @(negedge clk_i);
    void'(model_load());
    send_tx(8'h77);
    for (int i = 0; i < 3; i++) begin
      sck_i = 1'b1;
      repeat (H) @(negedge clk_i);
      sck_i  = 1'b0;
      mosi_i = 1'($urandom);
      repeat (H) @(negedge clk_i);
    end
    n_total++;
    if ({busy_o, tx_ready_o} !== 2'b10)
      $display("FAIL midbyte_pre: busy/ready got %b required 10", {busy_o, tx_ready_o});
    else n_pass++;
    rst_ni = 1'b0;
    cs_ni  = 1'b1;
    #1;
    n_total++;
    if ({miso_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o, overrun_o} !== 13'b0_1_0_00000000_0_0)
      $display("FAIL midbyte_reset: got %b required 0_1_0_00000000_0_0",
               {miso_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o, overrun_o});
    else n_pass++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tx_model_q.delete();
    repeat (20) @(negedge clk_i);
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL midbyte_idle: busy_o=%b required 0", busy_o);
    else n_pass++;
    rx_q.delete();
    mosi_bytes[0] = 8'($urandom);
    e0 = model_load();
    void'(model_load());
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 1'b0, 8'h00);
    n_total++;
    if (miso_bytes[0] !== e0 || rx_q.size() != 1 || rx_q[0] !== mosi_bytes[0])
      $display("FAIL midbyte_next: miso %h rx %h (%0d) required %h rx %h", miso_bytes[0], rx_q[0],
               rx_q.size(), e0, mosi_bytes[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] e[4];
    logic       pol, pha, lsb, q0, q1;
    logic [7:0] t0, t1;
    int         nb;
    for (int it = 0; it < 8; it++) begin
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
      q0  = 1'($urandom); q1  = 1'($urandom);
      t0  = 8'($urandom); t1  = 8'($urandom);
      nb  = 1 + int'($urandom_range(0, 2));
      for (int k = 0; k < nb; k++) mosi_bytes[k] = 8'($urandom);
      rx_q.delete();
      if (q0) send_tx(t0);
      e[0] = model_load();
      if (q1) tx_model_q.push_back(t1);
      for (int k = 1; k <= nb; k++) e[k] = model_load();
      spi_xfer(pol, pha, lsb, 8 * nb, q1, t1);
      n_total++;
      if (ready_seen !== 1'b1) $display("FAIL rnd%0d_ready: got %b required 1", it, ready_seen);
      else n_pass++;
      n_total++;
      if (rx_q.size() != nb) $display("FAIL rnd%0d_rx_count: got %0d required %0d", it, rx_q.size(), nb);
      else n_pass++;
      for (int k = 0; k < nb; k++) begin
        n_total++;
        if (miso_bytes[k] !== e[k])
          $display("FAIL rnd%0d_miso%0d: got %h required %h (mode %b%b lsb %b)", it, k,
                   miso_bytes[k], e[k], pol, pha, lsb);
        else n_pass++;
        if (k < rx_q.size()) begin
          n_total++;
          if (rx_q[k] !== mosi_bytes[k])
            $display("FAIL rnd%0d_rx%0d: got %h required %h", it, k, rx_q[k], mosi_bytes[k]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    en_i        = 1'b1;
    pol_i       = 1'b0;
    pha_i       = 1'b0;
    lsb_first_i = 1'b0;
    sck_i       = 1'b0;
    cs_ni       = 1'b1;
    mosi_i      = 1'b0;
    tx_data_i   = 8'h00;
    tx_valid_i  = 1'b0;
    rx_ready_i  = 1'b1;
    repeat (3) @(negedge clk_i);
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_mid_byte();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
